// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns each bit of an 8-bit LED port into a PWM-driven LED
// whose brightness ramps (or snaps) toward full-on / off.
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 1024,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] level_in,
  input  logic       fade_en,
  output logic [7:0] led_out,
  output logic       busy
);

  localparam int                MAX    = (1 << PWM_BITS) - 1;
  localparam int                DIV_W  = $clog2(FADE_DIV);
  localparam logic [PWM_BITS-1:0] FULL = PWM_BITS'(MAX);
  localparam logic [PWM_BITS:0] STEP_X = (PWM_BITS + 1)'(STEP);

  logic [7:0]          level_q;
  logic [PWM_BITS-1:0] bright     [8];
  logic [PWM_BITS-1:0] bright_nxt [8];
  logic [PWM_BITS-1:0] tgt        [8];
  logic [PWM_BITS:0]   up_sum     [8];
  logic [PWM_BITS:0]   dn_diff    [8];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [7:0]          led_nxt;
  logic                busy_nxt;

  // Fade tick: one clock at the end of every prescaler period.
  always_comb begin
    tick = (div_cnt == DIV_W'(FADE_DIV - 1));
  end

  // Per-channel target, saturating brightness step, PWM compare and busy.
  // The step is done one bit wider so overflow/borrow are visible; a set
  // top bit of dn_diff means the subtraction went below zero.
  always_comb begin
    led_nxt  = '0;
    busy_nxt = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      tgt[i]        = level_q[i] ? FULL : '0;
      up_sum[i]     = {1'b0, bright[i]} + STEP_X;
      dn_diff[i]    = {1'b0, bright[i]} - STEP_X;
      bright_nxt[i] = bright[i];
      if (!fade_en) begin
        bright_nxt[i] = tgt[i];
      end else if (tick) begin
        if (bright[i] < tgt[i]) begin
          bright_nxt[i] = (up_sum[i] > {1'b0, tgt[i]}) ? tgt[i] : up_sum[i][PWM_BITS-1:0];
        end else if (bright[i] > tgt[i]) begin
          bright_nxt[i] = (dn_diff[i][PWM_BITS] || (dn_diff[i] < {1'b0, tgt[i]}))
                          ? tgt[i] : dn_diff[i][PWM_BITS-1:0];
        end
      end
      led_nxt[i] = (bright[i] > pwm_cnt);
      busy_nxt   = busy_nxt | (bright[i] != tgt[i]);
    end
  end

  // State registers: input capture, counters, brightness and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
      led_out <= '0;
      busy    <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        bright[i] <= '0;
      end
    end else begin
      level_q <= level_in;
      pwm_cnt <= (pwm_cnt == PWM_BITS'(MAX - 1)) ? '0 : pwm_cnt + 1'b1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      led_out <= led_nxt;
      busy    <= busy_nxt;
      for (int unsigned i = 0; i < 8; i++) begin
        bright[i] <= bright_nxt[i];
      end
    end
  end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream consumer of the 8-bit LED PIO output port on the Nios system bus.
- Turns each on/off bit into a PWM-driven LED that ramps brightness smoothly between off and full-on, instead of switching hard.
- Sits between the PIO `out_port` and the board LED pins.
- Single clock domain, shared with the PIO.

Parameters:
- `PWM_BITS`, 8, brightness/PWM resolution; full scale `MAX` = 2^PWM_BITS - 1.
- `FADE_DIV`, 1024, clocks per fade tick; legal range ≥ 2.
- `STEP`, 1, brightness change per fade tick; legal range 1..MAX.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `level_in`  in  8  requested LED state from the PIO `out_port`; bit i = 1 requests full-on.
- `fade_en`  in  1  1 = ramp brightness gradually; 0 = brightness jumps straight to target.
- `led_out`  out  8  PWM drive to the LEDs; registered.
- `busy`  out  1  high while any channel brightness differs from its target; registered.

Behaviour:
- One clock (`clk`). Reset is asynchronous and active-low (`reset_n`). Assertion immediately clears every register.
- Reset values: `level_q`=0, `bright[0..7]`=0, `pwm_cnt`=0, `div_cnt`=0, `led_out`=0, `busy`=0.
- Reset mid-fade abandons the ramp. After release, all channels restart from 0.

Input stage:
- `level_in` is registered into `level_q` every clock.
- Target for channel i: `tgt[i]` = `level_q[i]` ? MAX : 0.

Fade prescaler:
- `div_cnt` counts 0..FADE_DIV-1 and wraps.
- `tick` = (`div_cnt` == FADE_DIV-1), asserted for one clock per period.
- The prescaler runs continuously regardless of `fade_en` or `level_in`.

Brightness update, per channel, every clock:
- `fade_en`=0: `bright[i]` <= `tgt[i]`.
- `fade_en`=1 and `tick`:
  - if `bright` < `tgt`: `bright` <= min(`bright`+STEP, `tgt`).
  - if `bright` > `tgt`: `bright` <= max(`bright`-STEP, `tgt`).
  - else hold.
- `fade_en`=1 and no tick: hold.
- Saturating arithmetic: never overshoot, never wrap. Compute in PWM_BITS+1 bits internally.
- A target reversal mid-ramp takes effect on the next tick, starting from the current brightness. No restart from an endpoint.

PWM:
- `pwm_cnt` counts 0..MAX-1 and wraps, so the period is MAX clocks.
- `led_out[i]` <= (`bright[i]` > `pwm_cnt`), registered.
- Consequences:
  - `bright`=0 gives constant 0.
  - `bright`=MAX gives constant 1.
  - `bright`=k gives exactly k high cycles per period.

Busy:
- `busy` <= OR over i of (`bright[i]` != `tgt[i]`), computed from current register values.

Latency, with `fade_en`=0:
- `level_in` change at edge N is captured in `level_q` at N+1.
- `bright` updates at N+2.
- `led_out` reflects the new level at N+3 (for full-on/off).

Fade duration:
- A full ramp 0→MAX takes ceil(MAX/STEP) ticks, i.e. ≈ ceil(MAX/STEP)·FADE_DIV clocks.

Mode switching:
- Toggling `fade_en` 1→0 mid-ramp snaps every channel to target on the next clock.
- Toggling 0→1 has no visible effect until the next target change.

Independence:
- Channels are independent.
- Simultaneous rising and falling channels each move toward their own target on the same tick.

Test Plan:
Sim parameters: PWM_BITS=4 (MAX=15), FADE_DIV=4, STEP=1 unless stated.
1. Reset: hold `reset_n`=0 with `level_in`=8'hFF → `led_out`=0, `busy`=0. Release → `busy`=1 within 2 clocks of `level_q` capture. Assert `reset_n` mid-ramp → all outputs 0 immediately (asynchronous).
2. Snap mode: `fade_en`=0, `level_in` 8'h00→8'hA5 → `led_out`=8'hA5 steady from 3rd clock after change, constant across full PWM periods; `busy` stays 0 after settle.
3. Fade-up: `fade_en`=1, `level_in`=8'h01 → `bright[0]` increments by 1 every 4 clocks. Reaches 15 after 15 ticks (60 clocks ±4), then `busy` falls. At `bright`=5, `led_out[0]` is high exactly 5 of every 15 clocks.
4. Reversal: fade-up to `bright`=7, then `level_in`=8'h00 → next tick gives 6, then descends to 0 without overshoot or wrap. `led_out[0]`=0 constant at end.
5. Saturation: STEP=4 build, fade 0→15 → sequence 4, 8, 12, 15 (clamped). Down: 11, 7, 3, 0.
6. Mixed channels: start from 8'h0F settled, apply 8'hF0 with `fade_en`=1 → ch0-3 descend and ch4-7 ascend on the same ticks. Switching `fade_en`=0 mid-ramp → all settle next clock, `busy`=0 one clock later.
